// File: rtl/ccff_chain_loader.sv
// Serialises host words LSB-first into a ccff configuration chain and stops after CHAIN_LEN shifts.
// Optional readback CRC-16-CCITT over ccff_tail is built when CCFF_LOADER_READBACK_EN is defined.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 36,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              load_start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic [15:0]       readback_crc
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int BW = $clog2(WORD_W + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);
  localparam logic [BW-1:0] WORD_CNT = BW'(WORD_W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     bit_cnt, bit_cnt_nxt;
  logic [BW-1:0]     buf_cnt, buf_cnt_nxt;
  logic [WORD_W-1:0] sbuf, sbuf_nxt;
  logic              accept;
  int                remain;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      buf_cnt <= '0;
      sbuf    <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      buf_cnt <= buf_cnt_nxt;
      sbuf    <= sbuf_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    buf_cnt_nxt   = buf_cnt;
    sbuf_nxt      = sbuf;
    in_ready      = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    accept        = 1'b0;
    remain        = 0;
    case (state)
      IDLE: begin
        if (load_start) begin
          state_nxt   = SHIFT;
          bit_cnt_nxt = '0;
          buf_cnt_nxt = '0;
          sbuf_nxt    = '0;
        end
      end
      SHIFT: begin
        busy          = 1'b1;
        // Taking a word while the last buffered bit leaves keeps the stream gap-free.
        in_ready      = (buf_cnt == '0) ||
                        (buf_cnt == BW'(1) && bit_cnt < LAST_BIT);
        ccff_shift_en = (buf_cnt != '0);
        ccff_head     = ccff_shift_en & sbuf[0];
        accept        = in_valid & in_ready;
        if (ccff_shift_en) begin
          sbuf_nxt    = sbuf >> 1;
          buf_cnt_nxt = buf_cnt - BW'(1);
          bit_cnt_nxt = bit_cnt + CW'(1);
          if (bit_cnt == LAST_BIT) state_nxt = DONE;
        end
        if (accept) begin
          // Bits still owed to the chain after this edge; surplus word bits are dropped.
          remain      = CHAIN_LEN - int'(bit_cnt) - int'(ccff_shift_en);
          sbuf_nxt    = in_data;
          buf_cnt_nxt = (remain < WORD_W) ? BW'(remain) : WORD_CNT;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef CCFF_LOADER_READBACK_EN
  logic [15:0] crc;
  logic        crc_fb;

  assign crc_fb = crc[15] ^ ccff_tail;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      crc <= 16'hFFFF;
    end else if (state == IDLE && load_start) begin
      crc <= 16'hFFFF;
    end else if (ccff_shift_en) begin
      crc <= {crc[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
    end
  end

  assign readback_crc = crc;
`else
  logic unused_tail;
  assign unused_tail  = ccff_tail;
  assign readback_crc = 16'hFFFF;
`endif

endmodule
